// File: rtl/interval_arbiter.sv
// ============================================================================
// interval_arbiter : round-robin scheduler for one shared down-counting
//                    interval timer, with tagged completion pulse.
// Revision: 1.0
// ============================================================================
`default_nettype none

module interval_arbiter #(
  parameter int NREQ = 4,
  parameter int W    = 4,
  parameter int IDW  = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic [NREQ-1:0]   req,
  input  logic [NREQ*W-1:0] dur,
  output logic [NREQ-1:0]   gnt,
  output logic              busy,
  output logic [W-1:0]      count,
  output logic              done,
  output logic [IDW-1:0]    done_id
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [IDW-1:0]  ptr_q, ptr_d;
  logic [IDW-1:0]  idx_q, idx_d;
  logic [NREQ-1:0] gnt_q, gnt_d;
  logic [W-1:0]    count_q, count_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic [IDW-1:0]  done_id_q, done_id_d;

  logic            arb_found;
  logic [IDW-1:0]  arb_idx;
  logic [NREQ-1:0] arb_oh;
  logic [W-1:0]    arb_dur;
  logic [IDW-1:0]  ptr_next;

  // Winner is the requester with the smallest circular distance from ptr.
  always_comb begin
    int best;
    int off;
    arb_found = 1'b0;
    arb_idx   = '0;
    arb_oh    = '0;
    arb_dur   = '0;
    best      = NREQ;
    off       = 0;
    for (int c = 0; c < NREQ; c++) begin
      off = c - int'(ptr_q);
      if (off < 0) begin
        off = off + NREQ;
      end
      if (req[c] && (off < best)) begin
        best      = off;
        arb_found = 1'b1;
        arb_idx   = IDW'(c);
        arb_oh    = '0;
        arb_oh[c] = 1'b1;
        arb_dur   = dur[c*W +: W];
      end
    end
  end

  assign ptr_next = (idx_q == IDW'(NREQ - 1)) ? '0 : (idx_q + IDW'(1));

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    idx_d     = idx_q;
    gnt_d     = gnt_q;
    count_d   = count_q;
    done_d    = 1'b0;
    done_id_d = '0;
    case (state_q)
      IDLE: begin
        if (arb_found) begin
          state_d = RUN;
          idx_d   = arb_idx;
          gnt_d   = arb_oh;
          count_d = arb_dur;
        end
      end
      RUN: begin
        // Zero check wins over en so a paused interval at 0 still completes.
        if (count_q == '0) begin
          state_d   = DONE;
          gnt_d     = '0;
          done_d    = 1'b1;
          done_id_d = idx_q;
        end else if (en) begin
          count_d = count_q - W'(1);
        end
      end
      DONE: begin
        state_d = IDLE;
        ptr_d   = ptr_next;
      end
      default: begin
        state_d = IDLE;
        gnt_d   = '0;
        count_d = '0;
      end
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= IDLE;
      ptr_q     <= '0;
      idx_q     <= '0;
      gnt_q     <= '0;
      count_q   <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      done_id_q <= '0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      idx_q     <= idx_d;
      gnt_q     <= gnt_d;
      count_q   <= count_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      done_id_q <= done_id_d;
    end
  end

  assign gnt     = gnt_q;
  assign busy    = busy_q;
  assign count   = count_q;
  assign done    = done_q;
  assign done_id = done_id_q;

endmodule

`default_nettype wire
